imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_if.sv | 22 ++
 rtl/imem_responder.sv | 119 +++++++++++
 tb/tb_imem_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch request/response bus between a PC-side master and the instruction memory responder.
// Both directions use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: synchronous-read word store, one read stage, 2-entry in-order response buffer.
// Optional macro IMEM_MISALIGN_CHECK_EN turns a non-word-aligned req_addr into an error response.
module imem_responder #(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013,
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    imem_responder_if.slave bus,
    input  logic          flush,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_idx,
    input  logic [31:0]   ld_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_q;

    logic        inf_valid_q, inf_valid_d;
    logic        inf_err_q,   inf_err_d;
    logic [31:0] inf_addr_q,  inf_addr_d;

    logic [1:0]        cnt_q, cnt_d;
    logic [1:0][31:0]  b_instr_q, b_instr_d;
    logic [1:0][31:0]  b_addr_q,  b_addr_d;
    logic [1:0]        b_err_q,   b_err_d;

    logic       req_acc, rsp_pop, in_range, req_err;
    logic [1:0] occ;
    logic       slot;

    assign in_range = {2'b00, bus.req_addr[31:2]} < 32'(DEPTH);
`ifdef IMEM_MISALIGN_CHECK_EN
    assign req_err  = !in_range || (bus.req_addr[1:0] != 2'b00);
`else
    assign req_err  = !in_range;
`endif

    assign occ     = cnt_q + {1'b0, inf_valid_q};
    assign rsp_pop = bus.rsp_valid && bus.rsp_ready;
    // A pop frees a slot for a same-cycle accept only when the buffer is not full, so a full
    // buffer reopens req_ready one cycle after it drains.
    assign bus.req_ready = reset_n && !flush && ((occ < 2'd2) || (rsp_pop && (cnt_q != 2'd2)));
    assign req_acc       = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = (cnt_q != 2'd0);
    assign bus.rsp_instr = b_instr_q[0];
    assign bus.rsp_addr  = b_addr_q[0];
    assign bus.rsp_err   = b_err_q[0];

    // Storage is never reset; out-of-range or rejected requests leave the array unread.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_idx] <= ld_data;
        end
        if (req_acc && !req_err) begin
            rd_data_q <= mem[bus.req_addr[AW+1:2]];
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        b_instr_d   = b_instr_q;
        b_addr_d    = b_addr_q;
        b_err_d     = b_err_q;
        inf_valid_d = req_acc;
        inf_addr_d  = inf_addr_q;
        inf_err_d   = inf_err_q;
        slot        = 1'b0;

        if (req_acc) begin
            inf_addr_d = bus.req_addr;
            inf_err_d  = req_err;
        end

        // Entry 0 is always the head; a pop shifts entry 1 down.
        if (rsp_pop) begin
            b_instr_d[0] = b_instr_q[1];
            b_addr_d[0]  = b_addr_q[1];
            b_err_d[0]   = b_err_q[1];
            cnt_d        = cnt_q - 2'd1;
        end

        if (inf_valid_q) begin
            slot            = cnt_d[0];
            b_instr_d[slot] = inf_err_q ? NOP_WORD : rd_data_q;
            b_addr_d[slot]  = inf_addr_q;
            b_err_d[slot]   = inf_err_q;
            cnt_d           = cnt_d + 2'd1;
        end

        if (flush) begin
            cnt_d       = 2'd0;
            inf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= 2'd0;
            b_instr_q   <= '0;
            b_addr_q    <= '0;
            b_err_q     <= '0;
            inf_valid_q <= 1'b0;
            inf_addr_q  <= 32'd0;
            inf_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            b_instr_q   <= b_instr_d;
            b_addr_q    <= b_addr_d;
            b_err_q     <= b_err_d;
            inf_valid_q <= inf_valid_d;
            inf_addr_q  <= inf_addr_d;
            inf_err_q   <= inf_err_d;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: driver tasks push expected responses, a negedge monitor pops and compares.
module tb_imem_responder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       ld_we;
    logic [7:0] ld_idx;
    logic [31:0] ld_data;
    int         cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // {err, addr, instr}
    logic [64:0] exp_q[$];
    int          pop_cyc[$];

    imem_responder_if bus();

    imem_responder #(.DEPTH(256), .NOP_WORD(32'h0000_0013)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .flush   (flush),
        .ld_we   (ld_we),
        .ld_idx  (ld_idx),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got instr %08h addr %08h, expected no response",
                         bus.rsp_instr, bus.rsp_addr);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                chk("rsp_instr", bus.rsp_instr, e[31:0]);
                chk("rsp_addr",  bus.rsp_addr,  e[63:32]);
                chk("rsp_err",   {31'd0, bus.rsp_err}, {31'd0, e[64]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_idx  = idx;
        ld_data = data;
        tick();
        ld_we   = 1'b0;
    endtask

    // Holds the request until accepted; the expectation is queued once acceptance is certain.
    task automatic send(input logic [31:0] addr, input logic [31:0] ei, input logic ee);
        bit done;
        done = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                exp_q.push_back({ee, addr, ei});
                done = 1'b1;
            end
        end
        if (!done) chk("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.rsp_valid === 1'b0) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        flush         = 1'b0;
        ld_we         = 1'b0;
        ld_idx        = 8'd0;
        ld_data       = 32'd0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'd0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        chk("rst_rsp_instr", bus.rsp_instr, 32'd0);
        chk("rst_rsp_addr",  bus.rsp_addr,  32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        tick();

        load(8'd0,   32'h0050_0093);
        load(8'd1,   32'h00A0_0113);
        load(8'd2,   32'h1234_5678);
        load(8'd255, 32'hDEAD_BEEF);

        // Back-to-back fetches with consumer always ready
        bus.rsp_ready = 1'b1;
        pop_cyc.delete();
        send(32'h0, 32'h0050_0093, 1'b0);
        send(32'h4, 32'h00A0_0113, 1'b0);
        drain();
        chk("b2b_count", 32'(pop_cyc.size()), 32'd2);
        if (pop_cyc.size() == 2) chk("b2b_gap", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);

        // Out-of-range index; also one-cycle read latency
        bus.rsp_ready = 1'b0;
        send(32'h0000_0400, 32'h0000_0013, 1'b1);
        chk("lat_not_early", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("oor_instr", bus.rsp_instr, 32'h0000_0013);
        chk("oor_addr",  bus.rsp_addr,  32'h0000_0400);
        chk("oor_err",   {31'd0, bus.rsp_err}, 32'd1);
        bus.rsp_ready = 1'b1;
        drain();

        // Backpressure: two accepted, third held off, head stable
        bus.rsp_ready = 1'b0;
        send(32'h8,   32'h1234_5678, 1'b0);
        send(32'h3FC, 32'hDEAD_BEEF, 1'b0);
        chk("bp_ready_full", {31'd0, bus.req_ready}, 32'd0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_ready_low",   {31'd0, bus.req_ready}, 32'd0);
            chk("bp_hold_valid",  {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_hold_instr",  bus.rsp_instr, 32'h1234_5678);
            chk("bp_hold_addr",   bus.rsp_addr,  32'h0000_0008);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        chk("full_pop_ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        chk("after_pop_ready", {31'd0, bus.req_ready}, 32'd1);
        drain();
        chk("bp_end_ready", {31'd0, bus.req_ready}, 32'd1);

        // Flush with one buffered and one in flight
        bus.rsp_ready = 1'b0;
        send(32'h0, 32'h0050_0093, 1'b0);
        send(32'h4, 32'h00A0_0113, 1'b0);
        flush = 1'b1;
        #1;
        chk("flush_ready", {31'd0, bus.req_ready}, 32'd0);
        exp_q.delete();
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        chk("flush_inflight", {31'd0, bus.rsp_valid}, 32'd0);
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        send(32'h8, 32'h1234_5678, 1'b0);
        drain();

        // Low address bits
`ifdef IMEM_MISALIGN_CHECK_EN
        send(32'h2, 32'h0000_0013, 1'b1);
        send(32'h7, 32'h0000_0013, 1'b1);
`else
        send(32'h2, 32'h0050_0093, 1'b0);
        send(32'h7, 32'h00A0_0113, 1'b0);
`endif
        drain();

        // Same-cycle load and fetch of index 2 returns the old word
        ld_we   = 1'b1;
        ld_idx  = 8'd2;
        ld_data = 32'hCAFE_F00D;
        send(32'h8, 32'h1234_5678, 1'b0);
        ld_we   = 1'b0;
        send(32'h8, 32'hCAFE_F00D, 1'b0);
        drain();

        // Asynchronous reset with responses pending
        bus.rsp_ready = 1'b0;
        send(32'h0, 32'h0050_0093, 1'b0);
        send(32'h4, 32'h00A0_0113, 1'b0);
        chk("pre_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, bus.req_ready}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rerst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rerst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        bus.rsp_ready = 1'b1;
        send(32'h0,   32'h0050_0093, 1'b0);
        send(32'h3FC, 32'hDEAD_BEEF, 1'b0);
        send(32'h8,   32'hCAFE_F00D, 1'b0);
        drain();

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
